// File: rtl/writeback_unit.sv
// writeback_unit: write-side master for the integer register file.
// Merges single-cycle ALU results and FIFO-buffered load responses into one
// registered write port, and keeps a busy scoreboard of outstanding loads.
// Optional macro WB_FWD_EN adds same-cycle write forwarding compare ports.
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic [31:0]      busy,
  output logic [PTR_W:0]   fifo_count,
  output logic [4:0]       rd,
  output logic [31:0]      write_data,
  output logic             w_en
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]       fwd_r1,
  input  logic [4:0]       fwd_r2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data1,
  output logic [31:0]      fwd_data2
`endif
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             sel_valid;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic [31:0]      busy_next;

  // Ready is forced low while in reset so no response is taken then.
  assign ld_ready = rst_n && (fifo_count != FULL);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (fifo_count != '0);

  // Pick the write source: ALU first, otherwise the FIFO head.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Scoreboard update: clear on pop, then set on issue so a reissue wins.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[fifo_rd[rd_ptr]] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Registered write port; rd/data hold when nothing is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd         <= '0;
      write_data <= '0;
      w_en       <= 1'b0;
    end else if (sel_valid) begin
      rd         <= sel_rd;
      write_data <= sel_data;
      w_en       <= (sel_rd != 5'd0);
    end else begin
      w_en       <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  // Forward the in-flight write to readers of the same register.
  always_comb begin
    fwd_hit1  = w_en && (rd == fwd_r1) && (fwd_r1 != 5'd0);
    fwd_hit2  = w_en && (rd == fwd_r2) && (fwd_r2 != 5'd0);
    fwd_data1 = write_data;
    fwd_data2 = write_data;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic [2:0]  fifo_count;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        w_en;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_r1;
  logic [4:0]  fwd_r2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int passed = 0;
  int total  = 0;

  writeback_unit #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy(busy), .fifo_count(fifo_count),
    .rd(rd), .write_data(write_data), .w_en(w_en)
`ifdef WB_FWD_EN
    , .fwd_r1(fwd_r1), .fwd_r2(fwd_r2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h1111_2222;
    step(); step();
    total++; if (w_en !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", w_en); else passed++;
    total++; if (ld_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ld_ready); else passed++;
    total++; if (busy !== 32'h0) $display("FAIL reset_busy got=%h exp=0", busy); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else passed++;
    ld_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (ld_ready !== 1'b1) $display("FAIL release_ready got=%0b exp=1", ld_ready); else passed++;
    step();
    total++; if (fifo_count !== 3'd0) $display("FAIL release_count got=%0d exp=0", fifo_count); else passed++;
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    total++; if (w_en !== 1'b1) $display("FAIL alu_wen got=%0b exp=1", w_en); else passed++;
    total++; if (rd !== 5'd5) $display("FAIL alu_rd got=%0d exp=5", rd); else passed++;
    total++; if (write_data !== 32'hDEAD_BEEF) $display("FAIL alu_data got=%h exp=deadbeef", write_data); else passed++;
    step();
    total++; if (w_en !== 1'b0) $display("FAIL alu_wen_drop got=%0b exp=0", w_en); else passed++;
    total++; if (rd !== 5'd5) $display("FAIL alu_rd_hold got=%0d exp=5", rd); else passed++;
    total++; if (write_data !== 32'hDEAD_BEEF) $display("FAIL alu_data_hold got=%h exp=deadbeef", write_data); else passed++;
  endtask

  task automatic test_x0_discard();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    step();
    alu_valid = 1'b0;
    total++; if (w_en !== 1'b0) $display("FAIL x0_alu_wen got=%0b exp=0", w_en); else passed++;
    total++; if (write_data !== 32'h0000_1234) $display("FAIL x0_alu_data got=%h exp=00001234", write_data); else passed++;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_0055;
    step();
    ld_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) $display("FAIL x0_ld_push got=%0d exp=1", fifo_count); else passed++;
    step();
    total++; if (fifo_count !== 3'd0) $display("FAIL x0_ld_pop got=%0d exp=0", fifo_count); else passed++;
    total++; if (w_en !== 1'b0) $display("FAIL x0_ld_wen got=%0b exp=0", w_en); else passed++;
    total++; if (write_data !== 32'h0000_0055) $display("FAIL x0_ld_data got=%h exp=00000055", write_data); else passed++;
  endtask

  task automatic test_backlog();
    logic [4:0] exp_rd    [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [2:0] exp_count [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [2:0] cnt_fill  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic       rdy_fill  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // ALU busy for 6 edges while loads 0..4 are offered; only 4 fit.
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(i);
      ld_valid = 1'b1;
      ld_rd   = (i < 4) ? 5'(10 + i) : 5'd14;
      ld_data = (i < 4) ? 32'h1000 + 32'(i) : 32'h1004;
      step();
      total++; if (fifo_count !== cnt_fill[i]) $display("FAIL backlog_count[%0d] got=%0d exp=%0d", i, fifo_count, cnt_fill[i]); else passed++;
      total++; if (ld_ready !== rdy_fill[i]) $display("FAIL backlog_ready[%0d] got=%0b exp=%0b", i, ld_ready, rdy_fill[i]); else passed++;
      total++; if (rd !== 5'd1 || write_data !== 32'h100 + 32'(i)) $display("FAIL backlog_alu[%0d] got=%0d/%h exp=1/%h", i, rd, write_data, 32'h100 + 32'(i)); else passed++;
    end
    alu_valid = 1'b0;
    // Drain: load 4 is still offered and gets accepted after the first pop.
    for (int j = 0; j < 5; j++) begin
      ld_valid = (j < 2);
      step();
      total++; if (w_en !== 1'b1 || rd !== exp_rd[j]) $display("FAIL drain_rd[%0d] got=%0b/%0d exp=1/%0d", j, w_en, rd, exp_rd[j]); else passed++;
      total++; if (write_data !== 32'h1000 + 32'(j)) $display("FAIL drain_data[%0d] got=%h exp=%h", j, write_data, 32'h1000 + 32'(j)); else passed++;
      total++; if (fifo_count !== exp_count[j]) $display("FAIL drain_count[%0d] got=%0d exp=%0d", j, fifo_count, exp_count[j]); else passed++;
      if (j == 0) begin
        total++; if (ld_ready !== 1'b1) $display("FAIL drain_ready got=%0b exp=1", ld_ready); else passed++;
      end
    end
    ld_valid = 1'b0;
    step();
    total++; if (w_en !== 1'b0) $display("FAIL drain_idle_wen got=%0b exp=0", w_en); else passed++;
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    total++; if (busy !== 32'h0) $display("FAIL sb_x0 got=%h exp=0", busy); else passed++;
    iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    total++; if (busy !== 32'h0000_0080) $display("FAIL sb_set got=%h exp=00000080", busy); else passed++;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
    step();
    alu_valid = 1'b0;
    total++; if (busy !== 32'h0000_0080) $display("FAIL sb_alu_keep got=%h exp=00000080", busy); else passed++;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5A5_A5A5;
    step();
    ld_valid = 1'b0;
    total++; if (busy !== 32'h0000_0080) $display("FAIL sb_push_keep got=%h exp=00000080", busy); else passed++;
    step();
    total++; if (busy !== 32'h0) $display("FAIL sb_clear got=%h exp=0", busy); else passed++;
    total++; if (w_en !== 1'b1 || rd !== 5'd7 || write_data !== 32'hA5A5_A5A5) $display("FAIL sb_write got=%0b/%0d/%h exp=1/7/a5a5a5a5", w_en, rd, write_data); else passed++;
    // Reissue on the pop edge: set must win over clear.
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h5A5A_5A5A; iss_valid = 1'b0;
    step();
    ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    total++; if (busy !== 32'h0000_0080) $display("FAIL sb_reissue got=%h exp=00000080", busy); else passed++;
    total++; if (w_en !== 1'b1 || write_data !== 32'h5A5A_5A5A) $display("FAIL sb_reissue_write got=%0b/%h exp=1/5a5a5a5a", w_en, write_data); else passed++;
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h4444;
    iss_valid = 1'b1; iss_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2223;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h4445;
    step();
    total++; if (w_en !== 1'b1 || fifo_count !== 3'd2) $display("FAIL mid_pre got=%0b/%0d exp=1/2", w_en, fifo_count); else passed++;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    total++; if (w_en !== 1'b0) $display("FAIL mid_wen got=%0b exp=0", w_en); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL mid_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (busy !== 32'h0) $display("FAIL mid_busy got=%h exp=0", busy); else passed++;
    step();
    rst_n = 1'b1;
    step();
    total++; if (w_en !== 1'b0 || fifo_count !== 3'd0) $display("FAIL mid_after got=%0b/%0d exp=0/0", w_en, fifo_count); else passed++;
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    fwd_r1 = 5'd9; fwd_r2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_0009;
    step();
    alu_valid = 1'b0;
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hCAFE_0009) $display("FAIL fwd_hit1 got=%0b/%h exp=1/cafe0009", fwd_hit1, fwd_data1); else passed++;
    total++; if (fwd_hit2 !== 1'b0) $display("FAIL fwd_hit2 got=%0b exp=0", fwd_hit2); else passed++;
    step();
    total++; if (fwd_hit1 !== 1'b0) $display("FAIL fwd_idle got=%0b exp=0", fwd_hit1); else passed++;
  endtask
`endif

  initial begin
`ifdef WB_FWD_EN
    fwd_r1 = '0; fwd_r2 = '0;
`endif
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_alu_write();
    test_x0_discard();
    test_backlog();
    test_scoreboard();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_forward();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
